// File: rtl/elbeth_mem_pkg.sv
// Shared types and default widths for the elbeth memory arbiter.
package elbeth_mem_pkg;

    localparam int unsigned ELBETH_ADDR_W = 8;
    localparam int unsigned ELBETH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/elbeth_arb_pick.sv
// Combinational winner select for the two-master arbiter.
// ELBETH_ARB_RR_EN defined: ties go to the master that was not granted last.
// ELBETH_ARB_RR_EN undefined: fixed priority, m0 wins.
module elbeth_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifndef ELBETH_ARB_RR_EN
    // last_grant has no effect on fixed-priority arbitration
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick a winner; grant_id 0 selects m0, 1 selects m1
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
`ifdef ELBETH_ARB_RR_EN
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
`else
        grant_id = ~req0 & req1;
`endif
    end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Two-master arbiter in front of one elbeth_memory port.
// Arbitration policy selected by ELBETH_ARB_RR_EN (see elbeth_arb_pick).
module elbeth_mem_arbiter
    import elbeth_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ELBETH_ADDR_W,
    parameter int unsigned DATA_W = ELBETH_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_enable,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_data_in,
    input  logic [DATA_W/8-1:0]   m0_wr,
    output logic [DATA_W-1:0]     m0_data_out,
    output logic                  m0_ready,
    input  logic                  m1_enable,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_data_in,
    input  logic [DATA_W/8-1:0]   m1_wr,
    output logic [DATA_W-1:0]     m1_data_out,
    output logic                  m1_ready,
    output logic                  mem_enable,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data_in,
    output logic [DATA_W/8-1:0]   mem_wr,
    input  logic [DATA_W-1:0]     mem_data_out,
    input  logic                  mem_ready
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       grant_valid;
    logic       grant_id;
    logic       last_grant;
    logic       load;
    logic       done;

    elbeth_arb_pick u_pick (
        .req0        (m0_enable),
        .req1        (m1_enable),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, return to IDLE when the memory finishes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = grant_id ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (mem_ready && mem_enable) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request onto the memory port and hold it until done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_enable  <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_wr      <= '0;
            last_grant  <= 1'b1;
        end else if (load) begin
            mem_enable  <= 1'b1;
            mem_addr    <= grant_id ? m1_addr    : m0_addr;
            mem_data_in <= grant_id ? m1_data_in : m0_data_in;
            mem_wr      <= grant_id ? m1_wr      : m0_wr;
        end else if (done) begin
            mem_enable  <= 1'b0;
            last_grant  <= (state_q == BUSY1);
        end
    end

    // Route completion and read data to the granted master only
    always_comb begin
        m0_ready    = (state_q == BUSY0) && mem_ready;
        m1_ready    = (state_q == BUSY1) && mem_ready;
        m0_data_out = (state_q == BUSY0) ? mem_data_out : '0;
        m1_data_out = (state_q == BUSY1) ? mem_data_out : '0;
    end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Scoreboard bench for elbeth_mem_arbiter with a small behavioural memory.
module tb_elbeth_mem_arbiter;

    localparam int MEM_LAT = 2;

    typedef struct {
        bit          id;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_enable = 1'b0, m1_enable = 1'b0;
    logic [7:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_data_in = '0, m1_data_in = '0;
    logic [3:0]  m0_wr = '0, m1_wr = '0;
    logic [31:0] m0_data_out, m1_data_out;
    logic        m0_ready, m1_ready;
    logic        mem_enable;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_wr;
    logic [31:0] mem_data_out = '0;
    logic        mem_ready;
    logic        model_ready = 1'b0;
    logic        spur = 1'b0;

    logic [31:0] mem [256];
    int          cnt = 0;
    int          cyc = 0;
    int          rdy_cyc [2];
    int          checks = 0;
    int          errors = 0;
    exp_t        sb [$];

    elbeth_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_enable    (m0_enable),
        .m0_addr      (m0_addr),
        .m0_data_in   (m0_data_in),
        .m0_wr        (m0_wr),
        .m0_data_out  (m0_data_out),
        .m0_ready     (m0_ready),
        .m1_enable    (m1_enable),
        .m1_addr      (m1_addr),
        .m1_data_in   (m1_data_in),
        .m1_wr        (m1_wr),
        .m1_data_out  (m1_data_out),
        .m1_ready     (m1_ready),
        .mem_enable   (mem_enable),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_ready = model_ready | spur;

    // Memory: ready MEM_LAT cycles after enable rises, byte-masked writes
    always @(posedge clk) begin
        model_ready <= 1'b0;
        if (mem_enable && !model_ready) begin
            if (cnt == MEM_LAT - 1) begin
                model_ready <= 1'b1;
                cnt <= 0;
                if (mem_wr == 4'b0000) begin
                    mem_data_out <= mem[mem_addr];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wr[b]) mem[mem_addr][8*b +: 8] <= mem_data_in[8*b +: 8];
                    end
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop expected completion whenever a master sees ready
    always @(negedge clk) begin
        exp_t e;
        if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            if (m0_ready === 1'b1) begin
                rdy_cyc[0] = cyc;
                check("m1_ready_during_m0", 32'(m1_ready), 32'd0);
                check("m1_dout_during_m0", m1_data_out, 32'd0);
            end else begin
                rdy_cyc[1] = cyc;
                check("m0_ready_during_m1", 32'(m0_ready), 32'd0);
                check("m0_dout_during_m1", m0_data_out, 32'd0);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: got m%0d ready expected none", m1_ready ? 1 : 0);
            end else begin
                e = sb.pop_front();
                if ((m1_ready === 1'b1 ? 1'b1 : 1'b0) !== e.id) begin
                    errors++;
                    $display("FAIL ready_order: got m%0d expected m%0d", m1_ready ? 1 : 0, e.id);
                end else if (e.chk) begin
                    check("read_data", e.id ? m1_data_out : m0_data_out, e.data);
                end
            end
        end
    end

    task automatic issue(input bit id, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] w, input bit push, input logic [31:0] exp_rd);
        exp_t e;
        if (push) begin
            e.id = id; e.chk = (w == 4'b0000); e.data = exp_rd;
            sb.push_back(e);
        end
        if (id == 1'b0) begin
            m0_addr = a; m0_data_in = d; m0_wr = w; m0_enable = 1'b1;
        end else begin
            m1_addr = a; m1_data_in = d; m1_wr = w; m1_enable = 1'b1;
        end
    endtask

    // Wait (bounded) for this master's ready, then drop enable after the completing edge
    task automatic wait_ready(input bit id);
        int n = 0;
        while (((id == 1'b0) ? m0_ready : m1_ready) !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("m%0d_ready_timeout", id), 32'(n >= 40), 32'd0);
        @(posedge clk); #1;
        if (id == 1'b0) m0_enable = 1'b0; else m1_enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'hFFFF_FFFF;
        mem[5] = 32'h5555_5555;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_m0_dout", m0_data_out, 32'd0);
        check("rst_m1_dout", m1_data_out, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Stray mem_ready in IDLE is ignored
        @(negedge clk) spur = 1'b1;
        @(posedge clk); #1;
        check("spur_m0_ready", 32'(m0_ready), 32'd0);
        check("spur_m1_ready", 32'(m1_ready), 32'd0);
        check("spur_mem_enable", 32'(mem_enable), 32'd0);
        @(negedge clk) spur = 1'b0;

        // Single read by m0: enable in the next cycle
        @(negedge clk);
        issue(1'b0, 8'h02, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF);
        #1 check("rd_enable_same_cycle", 32'(mem_enable), 32'd0);
        @(posedge clk); #1;
        check("rd_mem_enable", 32'(mem_enable), 32'd1);
        check("rd_mem_addr", 32'(mem_addr), 32'h02);
        check("rd_mem_wr", 32'(mem_wr), 32'd0);
        wait_ready(1'b0);

        // Hold stability: m0 address change mid-access is ignored
        @(negedge clk);
        issue(1'b0, 8'h01, 32'h0, 4'b0000, 1'b1, 32'h1111_1111);
        @(posedge clk); #1;
        m0_addr = 8'h05;
        for (int k = 0; k < 10 && m0_ready !== 1'b1; k++) begin
            check("hold_mem_addr", 32'(mem_addr), 32'h01);
            @(posedge clk); #1;
        end
        wait_ready(1'b0);

        // Byte write by m1
        @(negedge clk);
        issue(1'b1, 8'h00, 32'h0000_00FF, 4'b0001, 1'b1, 32'h0);
        @(posedge clk); #1;
        check("wr_mem_wr", 32'(mem_wr), 32'h1);
        check("wr_mem_data_in", mem_data_in, 32'h0000_00FF);
        check("wr_mem_addr", 32'(mem_addr), 32'h00);
        wait_ready(1'b1);

        // Tie after an m1 grant: m0 first in both policies, one IDLE gap
        @(negedge clk);
        issue(1'b0, 8'h01, 32'h0, 4'b0000, 1'b1, 32'h1111_1111);
        issue(1'b1, 8'h02, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF);
        fork
            wait_ready(1'b0);
            wait_ready(1'b1);
        join
        check("tie1_gap", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'(MEM_LAT + 2));

        // Read back the byte write
        @(negedge clk);
        issue(1'b0, 8'h00, 32'h0, 4'b0000, 1'b1, 32'h0000_00FF);
        wait_ready(1'b0);

        // Tie after an m0 grant: round-robin serves m1 first
`ifdef ELBETH_ARB_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        @(negedge clk);
        if (first) begin
            issue(1'b1, 8'h00, 32'h0, 4'b0000, 1'b1, 32'h0000_00FF);
            issue(1'b0, 8'h05, 32'h0, 4'b0000, 1'b1, 32'h5555_5555);
        end else begin
            issue(1'b0, 8'h05, 32'h0, 4'b0000, 1'b1, 32'h5555_5555);
            issue(1'b1, 8'h00, 32'h0, 4'b0000, 1'b1, 32'h0000_00FF);
        end
        fork
            wait_ready(1'b0);
            wait_ready(1'b1);
        join
        check("tie2_gap", 32'(rdy_cyc[~first] - rdy_cyc[first]), 32'(MEM_LAT + 2));

        // Reset during BUSY1 abandons the access
        @(negedge clk);
        issue(1'b1, 8'h05, 32'h0, 4'b0000, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("busy1_mem_enable", 32'(mem_enable), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_mem_enable", 32'(mem_enable), 32'd0);
        check("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("async_rst_m1_ready", 32'(m1_ready), 32'd0);
        m1_enable = 1'b0;
        @(negedge clk) rst = 1'b1;

        // First tie after reset goes to m0
        @(negedge clk);
        issue(1'b0, 8'h02, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF);
        issue(1'b1, 8'h01, 32'h0, 4'b0000, 1'b1, 32'h1111_1111);
        @(posedge clk); #1;
        check("post_rst_tie_addr", 32'(mem_addr), 32'h02);
        fork
            wait_ready(1'b0);
            wait_ready(1'b1);
        join

        repeat (3) @(posedge clk);
        #1 check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elbeth_mem_arbiter.md
# elbeth_mem_arbiter

Two-requester arbiter sharing one port of `elbeth_memory` between a core data-access master (m0) and a loader/DMA master (m1). It latches the winning request, drives the memory port until the memory returns `ready`, and routes `ready` and read data back to the granted master only. It sits between the requesters and the memory port; the memory needs no changes.

## Interface
- `ADDR_W`, 8, memory address width.
- `DATA_W`, 32, data width; byte-write mask width is `DATA_W/8`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m0_enable`, `m1_enable`  in  1  request valid; held until the matching `mX_ready` is seen.
- `m0_addr`, `m1_addr`  in  `ADDR_W`  access address.
- `m0_data_in`, `m1_data_in`  in  `DATA_W`  write data.
- `m0_wr`, `m1_wr`  in  `DATA_W/8`  byte-write mask; 0 means read.
- `m0_data_out`, `m1_data_out`  out  `DATA_W`  read data; zero when that master is not granted.
- `m0_ready`, `m1_ready`  out  1  access complete, one-cycle pulse.
- `mem_enable`  out  1  to the memory port `enable`.
- `mem_addr`  out  `ADDR_W`  to the memory port.
- `mem_data_in`  out  `DATA_W`  to the memory port.
- `mem_wr`  out  `DATA_W/8`  to the memory port.
- `mem_data_out`  in  `DATA_W`  from the memory port.
- `mem_ready`  in  1  from the memory port; the access is done in any cycle where it is high while `mem_enable` is high.

## Operation
- FSM states: `IDLE`, `BUSY0`, `BUSY1`.
- `IDLE`:
  - If any `mX_enable` is high, pick a winner (see arbitration rules below).
  - Register that master's `addr`, `data_in` and `wr` into the `mem_*` outputs, set `mem_enable`=1 and go to `BUSY0` or `BUSY1`.
  - With no requests, stay in `IDLE` and drive `mem_enable`=0.
- `BUSYx`:
  - The `mem_*` outputs hold the latched values; master input changes are ignored.
  - `mx_ready` = `mem_ready` (combinational).
  - `mx_data_out` = `mem_data_out`; the other master's `data_out` and `ready` are 0.
  - When `mem_ready`=1: clear `mem_enable`, update `last_grant`=x and go to `IDLE`.
- Arbitration without the macro: fixed priority, m0 beats m1.
- A request from the non-granted master waits; no preemption.
- `mem_ready` seen while in `IDLE` is ignored.

## Timing
- Reset values: FSM=`IDLE`; `mem_enable`=0; `mem_addr`, `mem_data_in` and `mem_wr`=0; both `mX_ready`=0; both `mX_data_out`=0; `last_grant`=m1.
- A request seen in `IDLE` in cycle N gives `mem_enable`=1 in cycle N+1.
- `mX_ready` pulses in the first cycle ≥ N+1 where `mem_ready`=1.
- There is one mandatory `IDLE` cycle after every completion, so the finishing master can drop `enable` without being granted again.
- Back-to-back throughput: one access per (memory latency + 2) cycles.
- Reset mid-access: outputs clear at once (asynchronously). The access is abandoned and the master never sees `ready`.
- Both masters requesting in the same `IDLE` cycle: the arbitration rule decides; the loser is served on the next `IDLE`.

## Configuration
- `ELBETH_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie in `IDLE`, grant the master that is not `last_grant`.
  - A single requester is always granted.
- `ELBETH_ARB_RR_EN` undefined: fixed priority, m0 wins.
  - `last_grant` is still kept but does not affect arbitration.

## Structure
- Shared package `elbeth_mem_pkg`:
  - FSM state enum `arb_state_t` (`IDLE`/`BUSY0`/`BUSY1`).
  - `ELBETH_ADDR_W`=8 and `ELBETH_DATA_W`=32, used as the parameter defaults.
- One sub-module, `elbeth_arb_pick`: combinational winner select.
  - Inputs: the two `enable` bits and `last_grant`.
  - Output: `grant_valid` and `grant_id`.
  - All `ELBETH_ARB_RR_EN` logic lives here.
- The top level holds the FSM, the request-latch registers and the return muxes.

## Test plan
- Single read: m0 reads `addr`=0x02 with `wr`=0 → `mem_enable` in the next cycle with `mem_addr`=0x02; `m0_ready` pulses with `m0_data_out`=0xFFFFFFFF (previously written); `m1_ready` stays 0.
- Byte write: m1 writes `addr`=0x00, `data`=0xFF, `wr`=4'b0001 → `mem_wr`=4'b0001; `m1_ready` pulses; a later m0 read of 0x00 returns 0x000000FF.
- Tie: both masters request `addr` 0x01 and 0x02 in the same cycle → m0 is served first, m1 second after one `IDLE` cycle. With `ELBETH_ARB_RR_EN`, a second tie is served m1 first.
- Hold stability: m0 changes `m0_addr` from 0x01 to 0x05 mid-access → `mem_addr` stays 0x01 until `mem_ready`.
- Reset during `BUSY1`: assert `rst`=0 → `mem_enable`=0 immediately. After release, the FSM is `IDLE` and the next tie grants m0.
